// File: rtl/fft_frame_feeder.sv
// Turns a free-running sample stream into FFT_PTS-sample Avalon-ST frames.
// A show-ahead FIFO absorbs sink backpressure, and write-side framing only writes whole frames.
module fft_frame_feeder #(
    parameter int DATA_W     = 14,
    parameter int FFT_PTS    = 1024,
    parameter int PTS_W      = 11,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic [1:0]               out_error,
    output logic [PTS_W-1:0]         out_fftpts,
    output logic                     out_inverse,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [15:0]              frame_count
);

    localparam int IDX_W  = (FFT_PTS > 1) ? $clog2(FFT_PTS) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_PTS - 1);
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    wr_idx_reg, rd_idx_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic                overflow_reg;
    logic [15:0]         frame_count_reg;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];

    logic accept, full, empty, wr_en, rd_en, drop;

    // Full/empty come from the registered occupancy, so a same-cycle read never frees room.
    assign full   = (count_reg == FULL_CNT);
    assign empty  = (count_reg == '0);
    assign accept = in_valid && ((state_reg == CAPTURE) || enable);
    assign wr_en  = accept && !full;
    assign drop   = accept && full;
    assign rd_en  = !empty && out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = CAPTURE;
            CAPTURE: if (wr_en && (wr_idx_reg == LAST_IDX) && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            wr_idx_reg      <= '0;
            rd_idx_reg      <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            overflow_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                wr_idx_reg <= (wr_idx_reg == LAST_IDX) ? '0 : wr_idx_reg + IDX_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
                rd_idx_reg <= (rd_idx_reg == LAST_IDX) ? '0 : rd_idx_reg + IDX_W'(1);
                if (rd_idx_reg == LAST_IDX) frame_count_reg <= frame_count_reg + 16'd1;
            end
            if (wr_en && !rd_en)      count_reg <= count_reg + (ADDR_W + 1)'(1);
            else if (!wr_en && rd_en) count_reg <= count_reg - (ADDR_W + 1)'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)           overflow_reg <= 1'b1;
            else if (clear_ovf) overflow_reg <= 1'b0;
        end
    end

    // Storage has no reset; the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= in_data;
    end

    assign out_valid   = !empty;
    assign out_real    = empty ? '0 : mem[rd_ptr_reg];
    assign out_sop     = !empty && (rd_idx_reg == '0);
    assign out_eop     = !empty && (rd_idx_reg == LAST_IDX);
    assign out_imag    = '0;
    assign out_error   = 2'b00;
    assign out_fftpts  = PTS_W'(FFT_PTS);
    assign out_inverse = 1'b0;
    assign overflow    = overflow_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: stimulus pushes expected beats into a queue,
// and a negedge monitor pops and compares every accepted output beat.
module tb_fft_frame_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [13:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop, out_eop;
    logic [13:0] out_real, out_imag;
    logic [1:0]  out_error;
    logic [10:0] out_fftpts;
    logic        out_inverse;
    logic        overflow;
    logic        clear_ovf = 1'b0;
    logic [15:0] frame_count;

    typedef struct {
        logic [13:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    fft_frame_feeder dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag), .out_error(out_error),
        .out_fftpts(out_fftpts), .out_inverse(out_inverse), .overflow(overflow),
        .clear_ovf(clear_ovf), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of input, then return just after the active edge.
    task automatic send(input logic v, input logic [13:0] d, input logic en);
        in_valid = v;
        in_data  = d;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [13:0] d, input int idx);
        beat_t b;
        b.data = d;
        b.sop  = (idx == 0);
        b.eop  = (idx == 1023);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: one line per accepted beat is too noisy, so only mismatches print.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0d with no expected beat at %0t",
                                 out_real, $time);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_data", {18'b0, out_real}, {18'b0, e.data});
                        check("beat_sop", {31'b0, out_sop}, {31'b0, e.sop});
                        check("beat_eop", {31'b0, out_eop}, {31'b0, e.eop});
                    end
                end else if (!out_valid) begin
                    check("idle_sop_eop", {30'b0, out_sop, out_eop}, 32'd0);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and constant fields.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_sop", {31'b0, out_sop}, 0);
        check("rst_eop", {31'b0, out_eop}, 0);
        check("rst_real", {18'b0, out_real}, 0);
        check("rst_overflow", {31'b0, overflow}, 0);
        check("rst_frame_count", {16'b0, frame_count}, 0);
        check("fftpts", {21'b0, out_fftpts}, 1024);
        check("imag", {18'b0, out_imag}, 0);
        check("error", {30'b0, out_error}, 0);
        check("inverse", {31'b0, out_inverse}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Frame of 0..1023, enable dropped at index 500, streaming sink.
        out_ready = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            push_exp(14'(j), j);
            send(1'b1, 14'(j), j < 500);
            if (j == 0) begin
                check("latency_valid", {31'b0, out_valid}, 1);
                check("latency_sop", {31'b0, out_sop}, 1);
                check("latency_real", {18'b0, out_real}, 0);
            end
        end
        for (int j = 0; j < 10; j++) send(1'b1, 14'(9000 + j), 1'b0);
        send(1'b0, '0, 1'b0);
        wait_drain("drain_frame1");
        check("frame_count_1", {16'b0, frame_count}, 1);
        check("no_overflow_1", {31'b0, overflow}, 0);

        // Fill with the sink stalled; the 2049th sample is dropped.
        out_ready = 1'b0;
        for (int j = 0; j < 2049; j++) begin
            if (j < 2048) push_exp(14'(j), j % 1024);
            send(1'b1, 14'(j), 1'b1);
            if (j == 2047) check("ovf_before_full", {31'b0, overflow}, 0);
        end
        check("ovf_on_drop", {31'b0, overflow}, 1);
        check("full_head_sop", {31'b0, out_sop}, 1);
        clear_ovf = 1'b1;
        send(1'b1, 14'd4000, 1'b1);
        check("ovf_set_wins", {31'b0, overflow}, 1);
        send(1'b0, '0, 1'b1);
        check("ovf_cleared", {31'b0, overflow}, 0);
        clear_ovf = 1'b0;
        out_ready = 1'b1;
        send(1'b0, '0, 1'b1);
        wait_drain("drain_overflow");
        check("frame_count_3", {16'b0, frame_count}, 3);

        // Sink toggles every cycle, one sample every four cycles.
        for (int j = 0; j < 1024; j++) begin
            logic [13:0] d;
            d = 14'(j * 5 + 3);
            push_exp(d, j);
            for (int k = 0; k < 4; k++) begin
                out_ready = ~out_ready;
                send(k == 0, d, j < 1000);
            end
        end
        out_ready = 1'b1;
        send(1'b0, '0, 1'b0);
        wait_drain("drain_toggle");
        check("frame_count_4", {16'b0, frame_count}, 4);
        check("no_overflow_toggle", {31'b0, overflow}, 0);

        // Reset mid-frame with rd_idx at 300 and 1024 entries buffered.
        out_ready = 1'b0;
        for (int j = 0; j < 1324; j++) begin
            push_exp(14'(j + 200), j % 1024);
            send(1'b1, 14'(j + 200), 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (300) send(1'b0, '0, 1'b1);
        out_ready = 1'b0;
        check("mid_frame_remaining", exp_q.size(), 1024);
        check("frame_count_pre_reset", {16'b0, frame_count}, 4);
        reset = 1'b1;
        #1;
        check("reset_valid_now", {31'b0, out_valid}, 0);
        check("reset_frame_count", {16'b0, frame_count}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1'b0, '0, 1'b0);
        check("post_reset_valid", {31'b0, out_valid}, 0);
        check("post_reset_overflow", {31'b0, overflow}, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            push_exp(14'(j ^ 14'h2AA), j);
            send(1'b1, 14'(j ^ 14'h2AA), j < 10);
        end
        send(1'b0, '0, 1'b0);
        wait_drain("drain_after_reset");
        check("frame_count_after_reset", {16'b0, frame_count}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
